// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and
// writes them to consecutive instruction-memory addresses while holding the CPU.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] checksum,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  // Handshake: a byte moves on any rising edge where byte_valid and byte_ready
  // are both 1; byte_ready is high only in RECV, so the host may hold
  // byte_valid/byte_data steady for as long as it likes.

  state_t              state_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     wcnt_q;
  logic [ADDR_W:0]     wcnt_d;
  logic [1:0]          bcnt_q;
  logic [WORD_W-9:0]   asm_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_waddr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                done_q;
  logic                err_q;
  logic [WORD_W-1:0]   checksum_q;

  assign wcnt_d = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      checksum_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            if ((load_len != '0) && (load_len <= MAX_LEN)) begin
              len_q      <= load_len;
              wcnt_q     <= '0;
              bcnt_q     <= '0;
              asm_q      <= '0;
              checksum_q <= '0;
              state_q    <= S_RECV;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (byte_valid) begin
            if (bcnt_q == 2'd3) begin
              // Earlier bytes were shifted in from the top, so byte 0 sits at the LSB.
              mem_we_q    <= 1'b1;
              mem_waddr_q <= wcnt_q[ADDR_W-1:0];
              mem_wdata_q <= {byte_data, asm_q};
              bcnt_q      <= '0;
              state_q     <= S_WRITE;
            end else begin
              asm_q  <= {byte_data, asm_q[WORD_W-9:8]};
              bcnt_q <= bcnt_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          checksum_q <= checksum_q ^ mem_wdata_q;
          wcnt_q     <= wcnt_d;
          if (wcnt_d == len_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RECV;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = (state_q == S_RECV);
  assign busy       = (state_q != S_IDLE);
  assign cpu_hold   = busy;
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign checksum   = checksum_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes come from a word-list model,
// a per-cycle compare process checks writes and hold signals against it.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [6:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [31:0] checksum;
  logic [1:0]  dbg_state;

  imem_loader #(.ADDR_W(6), .WORD_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .checksum   (checksum),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          write_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic        hold_exp = 1'b0;
  logic [37:0] exp_q[$];
  logic [31:0] model_csum = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard / compare process, sampled on the falling edge
  always @(negedge clk) begin
    logic [37:0] e;
    if (mem_we === 1'b1) begin
      write_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_waddr !== e[37:32] || mem_wdata !== e[31:0]) begin
          errors++;
          $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                   mem_waddr, mem_wdata, e[37:32], e[31:0]);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    checks++;
    if (cpu_hold !== busy || (byte_ready === 1'b1 && busy !== 1'b1)) begin
      errors++;
      $display("FAIL hold_busy: cpu_hold %b busy %b byte_ready %b", cpu_hold, busy, byte_ready);
    end
    if (hold_exp) begin
      checks++;
      if (cpu_hold !== 1'b1) begin
        errors++;
        $display("FAIL cpu_hold_during_load: got %b expected 1", cpu_hold);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_load(input int n, input logic [31:0] words[$]);
    model_csum = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({i[5:0], words[i]});
      model_csum ^= words[i];
    end
  endtask

  task automatic pulse_start(input logic [6:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int n = 0;
    for (int s = 0; s < stall; s++) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom_range(0, 255));
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: byte_ready %b after %0d cycles", byte_ready, n);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_stall);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (max_stall > 0) ? $urandom_range(0, max_stall) : 0);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles", done, bound);
    end
  endtask

  initial begin
    logic [31:0] words[$];
    int          wc0;
    int          dc0;
    int          ec0;

    rst = 1'b1; load_start = 1'b0; load_len = '0;
    byte_valid = 1'b1; byte_data = 8'hAA;

    // reset values with byte_valid held high
    repeat (3) tick();
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_waddr",  32'(mem_waddr),  32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_cpu_hold",   32'(cpu_hold),   32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_checksum",   checksum,        32'd0);
    rst = 1'b0; byte_valid = 1'b0;
    tick();
    check("rst_no_write", 32'(write_cnt), 32'd0);

    // single word, back-to-back bytes, exact cycle timing
    words = '{32'h00108093};
    model_load(1, words);
    pulse_start(7'd1);
    check("single_busy_t1",  32'(busy),       32'd1);
    check("single_ready_t1", 32'(byte_ready), 32'd1);
    send_word(32'h00108093, 0);
    check("single_we_t5",    32'(mem_we),    32'd1);
    check("single_addr_t5",  32'(mem_waddr), 32'd0);
    check("single_data_t5",  mem_wdata,      32'h00108093);
    check("single_done_t5",  32'(done),      32'd0);
    tick();
    check("single_done_t6",  32'(done),      32'd1);
    check("single_csum",     checksum,       32'h00108093);
    check("single_csum_mdl", checksum,       model_csum);
    check("single_busy_t6",  32'(busy),      32'd1);
    tick();
    check("single_busy_t7",  32'(busy),      32'd0);
    check("single_done_t7",  32'(done),      32'd0);
    check("single_pending",  32'(exp_q.size()), 32'd0);

    // full depth, random byte_valid stalls
    words = {};
    for (int i = 0; i < 64; i++) words.push_back(32'h01000000 + 32'(i));
    model_load(64, words);
    wc0 = write_cnt;
    pulse_start(7'd64);
    hold_exp = 1'b1;
    for (int i = 0; i < 64; i++) send_word(words[i], 2);
    wait_done(20);
    hold_exp = 1'b0;
    check("full_writes",   32'(write_cnt - wc0), 32'd64);
    check("full_pending",  32'(exp_q.size()),    32'd0);
    check("full_csum_mdl", checksum,             model_csum);
    check("full_csum",     checksum,             32'h00000000);
    tick();
    check("full_busy_end", 32'(busy), 32'd0);
    repeat (2) tick();
    check("full_csum_hold", checksum, 32'h00000000);

    // rejected lengths
    ec0 = err_cnt;
    pulse_start(7'd0);
    check("len0_err",   32'(err),  32'd1);
    check("len0_busy",  32'(busy), 32'd0);
    tick();
    check("len0_err_off", 32'(err), 32'd0);
    pulse_start(7'd65);
    check("len65_err",  32'(err),  32'd1);
    check("len65_busy", 32'(busy), 32'd0);
    tick();
    check("len65_busy2", 32'(busy), 32'd0);
    check("bad_err_count", 32'(err_cnt - ec0), 32'd2);

    // load_start during a 2-word load is ignored
    words = '{32'hDEADBEEF, 32'h12345678};
    model_load(2, words);
    wc0 = write_cnt;
    ec0 = err_cnt;
    pulse_start(7'd2);
    send_word(words[0], 0);
    pulse_start(7'd5);
    check("ign_busy", 32'(busy), 32'd1);
    send_word(words[1], 1);
    wait_done(20);
    check("ign_csum",     checksum, 32'hCC99E897);
    check("ign_csum_mdl", checksum, model_csum);
    repeat (4) tick();
    check("ign_writes",  32'(write_cnt - wc0), 32'd2);
    check("ign_busy_end", 32'(busy), 32'd0);
    check("ign_no_err",  32'(err_cnt - ec0), 32'd0);
    check("ign_pending", 32'(exp_q.size()), 32'd0);

    // reset in the middle of word 1 of a 3-word load
    words = '{32'hA1B2C3D4};
    model_load(1, words);
    wc0 = write_cnt;
    dc0 = done_cnt;
    pulse_start(7'd3);
    send_word(32'hA1B2C3D4, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy),   32'd0);
    check("midrst_we",   32'(mem_we), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_writes", 32'(write_cnt - wc0), 32'd1);
    check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);

    words = '{32'h55AA0FF0};
    model_load(1, words);
    pulse_start(7'd1);
    send_word(words[0], 1);
    wait_done(20);
    check("post_csum",     checksum, 32'h55AA0FF0);
    check("post_csum_mdl", checksum, model_csum);
    tick();
    check("post_pending", 32'(exp_q.size()), 32'd0);
    check("post_busy",    32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
